// File: rtl/prog_mealy_fsm.sv
`default_nettype none
// ============================================================================
// Module   : prog_mealy_fsm
// Purpose  : Table-driven Mealy machine. Each {state, input} entry holds a
//            {next, out} pair written at run time. Provides free-run and
//            single-step advance, forced state load, a registered output,
//            a saturating step counter and visited-state tracking.
// Revision : 1.0 - initial release
// ============================================================================
module prog_mealy_fsm #(
  parameter int STATE_W     = 3,
  parameter int IN_W        = 1,
  parameter int OUT_W       = 1,
  parameter int RESET_STATE = 0,
  parameter int CNT_W       = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [IN_W-1:0]         x,
  input  logic                    run,
  input  logic                    step,
  input  logic                    force_en,
  input  logic [STATE_W-1:0]      force_state,
  input  logic                    cfg_we,
  input  logic [STATE_W-1:0]      cfg_state,
  input  logic [IN_W-1:0]         cfg_in,
  input  logic [STATE_W-1:0]      cfg_next,
  input  logic [OUT_W-1:0]        cfg_out,
  output logic [OUT_W-1:0]        y,
  output logic [OUT_W-1:0]        y_reg,
  output logic [STATE_W-1:0]      currentState,
  output logic [STATE_W-1:0]      nextState,
  output logic [CNT_W-1:0]        step_count,
  output logic [2**STATE_W-1:0]   visited
);

  localparam int NUM_STATES = 2**STATE_W;
  localparam int ENTRIES    = 2**(STATE_W+IN_W);
  localparam logic [STATE_W-1:0]    RST_ST  = STATE_W'(RESET_STATE);
  localparam logic [NUM_STATES-1:0] VIS_ONE = {{(NUM_STATES-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]      CNT_MAX = '1;

  // Transition table, row = state, column = input symbol
  logic [STATE_W-1:0] tbl_next [ENTRIES];
  logic [OUT_W-1:0]   tbl_out  [ENTRIES];

  logic [STATE_W+IN_W-1:0] cur_addr;
  logic [STATE_W+IN_W-1:0] cfg_addr;
  logic                    advance;
  logic [STATE_W-1:0]      state_d;

  assign cur_addr = {currentState, x};
  assign cfg_addr = {cfg_state, cfg_in};

  // Table storage: cleared on reset, one entry written per cfg_we cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        tbl_next[i] <= RST_ST;
        tbl_out[i]  <= '0;
      end
    end else if (cfg_we) begin
      tbl_next[cfg_addr] <= cfg_next;
      tbl_out[cfg_addr]  <= cfg_out;
    end
  end

  // Output logic: Mealy output and next state looked up combinationally
  always_comb begin
    y         = tbl_out[cur_addr];
    nextState = tbl_next[cur_addr];
  end

  // Next-state selection: force beats advance; a table write blocks advancing
  always_comb begin
    advance = (run | step) & ~cfg_we & ~force_en;
    state_d = currentState;
    if (force_en) begin
      state_d = force_state;
    end else if (advance) begin
      state_d = nextState;
    end
  end

  // State register plus registered output, step counter and visited mask
  always_ff @(posedge clk) begin
    if (reset) begin
      currentState <= RST_ST;
      y_reg        <= '0;
      step_count   <= '0;
      visited      <= VIS_ONE << RST_ST;
    end else begin
      currentState <= state_d;
      if (force_en) begin
        visited[force_state] <= 1'b1;
      end else if (advance) begin
        y_reg              <= y;
        visited[nextState] <= 1'b1;
        if (step_count != CNT_MAX) begin
          step_count <= step_count + CNT_W'(1);
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_prog_mealy_fsm.sv
`default_nettype none
// ============================================================================
// Module   : tb_prog_mealy_fsm
// Purpose  : Self-checking bench for prog_mealy_fsm against a behavioural
//            model of the transition table and advance rules.
// Revision : 1.0 - initial release
// ============================================================================
module tb_prog_mealy_fsm;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [0:0] x = '0;
  logic       run = 1'b0, step = 1'b0, force_en = 1'b0, cfg_we = 1'b0;
  logic [2:0] force_state = '0, cfg_state = '0, cfg_next = '0;
  logic [0:0] cfg_in = '0, cfg_out = '0;

  logic [0:0]  y, y_reg;
  logic [2:0]  cur_st, nxt_st;
  logic [15:0] step_count;
  logic [7:0]  visited;

  logic [0:0]  s_y, s_y_reg;
  logic [2:0]  s_cur, s_nxt;
  logic [1:0]  s_count;
  logic [7:0]  s_visited;

  int n_cmp = 0;
  int n_fail = 0;

  // Behavioural model: table as plain arrays, machine state as integers
  int m_next [16];
  int m_out  [16];
  int m_cur, m_yreg, m_cnt, m_cnt2, m_vis;

  prog_mealy_fsm dut (
    .clk(clk), .reset(reset), .x(x), .run(run), .step(step),
    .force_en(force_en), .force_state(force_state), .cfg_we(cfg_we),
    .cfg_state(cfg_state), .cfg_in(cfg_in), .cfg_next(cfg_next),
    .cfg_out(cfg_out), .y(y), .y_reg(y_reg), .currentState(cur_st),
    .nextState(nxt_st), .step_count(step_count), .visited(visited)
  );

  prog_mealy_fsm #(.CNT_W(2)) dut_sat (
    .clk(clk), .reset(reset), .x(x), .run(run), .step(step),
    .force_en(force_en), .force_state(force_state), .cfg_we(cfg_we),
    .cfg_state(cfg_state), .cfg_in(cfg_in), .cfg_next(cfg_next),
    .cfg_out(cfg_out), .y(s_y), .y_reg(s_y_reg), .currentState(s_cur),
    .nextState(s_nxt), .step_count(s_count), .visited(s_visited)
  );

  always #5 clk = ~clk;

  function automatic int idx(input int st, input int sym);
    return st * 2 + sym;
  endfunction

  // Apply one clock edge to the model, then to the DUT
  task automatic tick();
    int nx, ot;
    bit adv;
    if (reset) begin
      for (int i = 0; i < 16; i++) begin m_next[i] = 0; m_out[i] = 0; end
      m_cur = 0; m_yreg = 0; m_cnt = 0; m_cnt2 = 0; m_vis = 1;
    end else begin
      nx  = m_next[idx(m_cur, int'(x))];
      ot  = m_out[idx(m_cur, int'(x))];
      adv = (run || step) && !cfg_we && !force_en;
      if (cfg_we) begin
        m_next[idx(int'(cfg_state), int'(cfg_in))] = int'(cfg_next);
        m_out[idx(int'(cfg_state), int'(cfg_in))]  = int'(cfg_out);
      end
      if (force_en) begin
        m_cur = int'(force_state);
        m_vis = m_vis | (1 << m_cur);
      end else if (adv) begin
        m_cur  = nx;
        m_yreg = ot;
        m_vis  = m_vis | (1 << nx);
        if (m_cnt < 65535) m_cnt++;
        if (m_cnt2 < 3) m_cnt2++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    reset = 0; run = 0; step = 0; force_en = 0; cfg_we = 0;
  endtask

  task automatic cfg_write(input int st, input int sym, input int nx, input int ot);
    idle();
    cfg_we = 1; cfg_state = 3'(st); cfg_in = 1'(sym); cfg_next = 3'(nx); cfg_out = 1'(ot);
    tick();
    cfg_we = 0;
  endtask

  task automatic test_reset();
    reset = 1; run = 1; cfg_we = 1; cfg_state = 3'd0; cfg_in = 1'b0;
    cfg_next = 3'd6; cfg_out = 1'b1; x = 1'b0;
    tick();
    idle();
    #2;
    n_cmp++; if (cur_st !== 3'd0) begin n_fail++; $display("FAIL reset_state got=%0d exp=0", cur_st); end
    n_cmp++; if (y !== 1'b0) begin n_fail++; $display("FAIL reset_y got=%0d exp=0", y); end
    n_cmp++; if (y_reg !== 1'b0) begin n_fail++; $display("FAIL reset_yreg got=%0d exp=0", y_reg); end
    n_cmp++; if (step_count !== 16'd0) begin n_fail++; $display("FAIL reset_count got=%0d exp=0", step_count); end
    n_cmp++; if (visited !== 8'h01) begin n_fail++; $display("FAIL reset_visited got=%h exp=01", visited); end
    n_cmp++; if (nxt_st !== 3'd0) begin n_fail++; $display("FAIL reset_next got=%0d exp=0 (cfg write ignored)", nxt_st); end
  endtask

  task automatic test_program();
    int nt [16] = '{5,1, 3,2, 5,4, 3,2, 3,2, 5,1, 6,7, 6,0};
    int ot [16] = '{0,0, 0,0, 0,0, 1,0, 0,0, 1,1, 0,1, 1,0};
    int xs [4]  = '{1,0,0,1};
    for (int i = 0; i < 16; i++) cfg_write(i / 2, i % 2, nt[i], ot[i]);
    for (int k = 0; k < 4; k++) begin
      idle(); run = 1; x = 1'(xs[k]);
      #2;
      n_cmp++; if (int'(y) !== m_out[idx(m_cur, xs[k])]) begin n_fail++;
        $display("FAIL prog_y[%0d] got=%0d exp=%0d", k, y, m_out[idx(m_cur, xs[k])]); end
      n_cmp++; if (int'(nxt_st) !== m_next[idx(m_cur, xs[k])]) begin n_fail++;
        $display("FAIL prog_next[%0d] got=%0d exp=%0d", k, nxt_st, m_next[idx(m_cur, xs[k])]); end
      tick();
      n_cmp++; if (int'(cur_st) !== m_cur) begin n_fail++;
        $display("FAIL prog_state[%0d] got=%0d exp=%0d", k, cur_st, m_cur); end
    end
    idle(); #2;
    n_cmp++; if (int'(step_count) !== 4) begin n_fail++; $display("FAIL prog_count got=%0d exp=4", step_count); end
    n_cmp++; if (int'(visited) !== m_vis) begin n_fail++; $display("FAIL prog_visited got=%h exp=%h", visited, m_vis); end
  endtask

  task automatic test_single_step();
    idle(); force_en = 1; force_state = 3'd0; tick();
    idle(); x = 1'b0; step = 1; tick();
    idle(); tick(); tick();
    #2;
    n_cmp++; if (cur_st !== 3'd5 || int'(cur_st) !== m_cur) begin n_fail++;
      $display("FAIL step_state got=%0d exp=5", cur_st); end
    n_cmp++; if (int'(y_reg) !== m_yreg) begin n_fail++; $display("FAIL step_yreg got=%0d exp=%0d", y_reg, m_yreg); end
    n_cmp++; if (int'(step_count) !== m_cnt) begin n_fail++; $display("FAIL step_count got=%0d exp=%0d", step_count, m_cnt); end
  endtask

  task automatic test_priority();
    idle(); run = 1; x = 1'b0;
    cfg_we = 1; cfg_state = 3'd5; cfg_in = 1'b0; cfg_next = 3'd6; cfg_out = 1'b1;
    #2;
    n_cmp++; if (int'(y) !== m_out[idx(5, 0)]) begin n_fail++; $display("FAIL prio_old_y got=%0d exp=%0d", y, m_out[idx(5, 0)]); end
    n_cmp++; if (int'(nxt_st) !== m_next[idx(5, 0)]) begin n_fail++; $display("FAIL prio_old_next got=%0d exp=%0d", nxt_st, m_next[idx(5, 0)]); end
    tick();
    idle(); #2;
    n_cmp++; if (int'(cur_st) !== m_cur || cur_st !== 3'd5) begin n_fail++; $display("FAIL prio_hold got=%0d exp=5", cur_st); end
    n_cmp++; if (nxt_st !== 3'd6) begin n_fail++; $display("FAIL prio_new_next got=%0d exp=6", nxt_st); end
    n_cmp++; if (y !== 1'b1) begin n_fail++; $display("FAIL prio_new_y got=%0d exp=1", y); end
  endtask

  task automatic test_force();
    idle(); force_en = 1; force_state = 3'd7; run = 1; x = 1'b1;
    tick();
    idle(); #2;
    n_cmp++; if (cur_st !== 3'd7) begin n_fail++; $display("FAIL force_state got=%0d exp=7", cur_st); end
    n_cmp++; if (int'(step_count) !== m_cnt) begin n_fail++; $display("FAIL force_count got=%0d exp=%0d", step_count, m_cnt); end
    n_cmp++; if (int'(visited) !== m_vis || visited[7] !== 1'b1) begin n_fail++; $display("FAIL force_visited got=%h exp=%h", visited, m_vis); end
    n_cmp++; if (int'(y_reg) !== m_yreg) begin n_fail++; $display("FAIL force_yreg got=%0d exp=%0d", y_reg, m_yreg); end
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      reset       = ($urandom_range(0, 59) == 0);
      run         = ($urandom_range(0, 2) != 0);
      step        = ($urandom_range(0, 3) == 0);
      force_en    = ($urandom_range(0, 9) == 0);
      cfg_we      = ($urandom_range(0, 3) == 0);
      x           = 1'($urandom);
      force_state = 3'($urandom);
      cfg_state   = 3'($urandom);
      cfg_in      = 1'($urandom);
      cfg_next    = 3'($urandom);
      cfg_out     = 1'($urandom);
      #2;
      n_cmp++; if (int'(y) !== m_out[idx(m_cur, int'(x))] || int'(nxt_st) !== m_next[idx(m_cur, int'(x))]) begin
        n_fail++; $display("FAIL rand_comb[%0d] y/next got=%0d/%0d exp=%0d/%0d", k, y, nxt_st,
                           m_out[idx(m_cur, int'(x))], m_next[idx(m_cur, int'(x))]); end
      tick();
      n_cmp++; if (int'(cur_st) !== m_cur || int'(y_reg) !== m_yreg) begin
        n_fail++; $display("FAIL rand_state[%0d] state/yreg got=%0d/%0d exp=%0d/%0d", k, cur_st, y_reg, m_cur, m_yreg); end
      n_cmp++; if (int'(step_count) !== m_cnt || int'(visited) !== m_vis) begin
        n_fail++; $display("FAIL rand_cnt_vis[%0d] got=%0d/%h exp=%0d/%h", k, step_count, visited, m_cnt, m_vis); end
    end
    idle();
  endtask

  task automatic test_saturation();
    int exp_seq [5] = '{1, 2, 3, 3, 3};
    idle(); reset = 1; tick();
    idle(); run = 1; x = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      n_cmp++; if (int'(s_count) !== exp_seq[k] || int'(s_count) !== m_cnt2) begin n_fail++;
        $display("FAIL sat_count[%0d] got=%0d exp=%0d", k, s_count, exp_seq[k]); end
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_program();
    test_single_step();
    test_priority();
    test_force();
    test_random();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
